// File: rtl/fp_cmp_arbiter_pkg.sv
// Shared definitions for the FP compare arbiter: FloPoCo field layout
// (exp 11, frac 19), exception encodings and drain FSM state codes.
package fp_cmp_pkg;

    localparam int FP_EXP_W    = 11;
    localparam int FP_FRAC_W   = 19;
    localparam int FP_FRAC_LSB = 0;
    localparam int FP_EXP_LSB  = FP_FRAC_LSB + FP_FRAC_W;
    localparam int FP_SIGN_BIT = FP_EXP_LSB + FP_EXP_W;
    localparam int FP_EXC_LSB  = FP_SIGN_BIT + 1;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    function automatic logic isNan(input logic [1:0] exc);
        return exc == EXC_NAN;
    endfunction

endpackage

// File: rtl/fp_cmp_arbiter_rr.sv
// Round-robin grant: lowest requester at or above the pointer wins, then
// wraps to the lowest below it. Pointer moves past each winner.
module rr_arbiter
    import fp_cmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gntId,
    output logic            o_any
);

    logic [IDW-1:0] r_ptr;
    logic           w_found;

    always_comb begin
        o_gnt   = '0;
        o_gntId = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (i_en && !w_found && i_req[i] && (IDW'(i) >= r_ptr)) begin
                o_gnt[i] = 1'b1;
                o_gntId  = IDW'(i);
                w_found  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (i_en && !w_found && i_req[i] && (IDW'(i) < r_ptr)) begin
                o_gnt[i] = 1'b1;
                o_gntId  = IDW'(i);
                w_found  = 1'b1;
            end
        end
    end

    assign o_any = w_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (o_gntId == IDW'(NREQ - 1)) ? '0 : o_gntId + IDW'(1);
        end
    end

endmodule

// File: rtl/fp_cmp_arbiter.sv
// Shares one pipelined FP compare unit among NREQ requesters, tagging each
// issue with its requester id. Optional NaN flag: define FP_CMP_UNORD_EN.
module fp_cmp_arbiter
    import fp_cmp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int CMP_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           i_req_valid,
    output logic [NREQ-1:0]           o_req_ready,
    input  logic [NREQ*(WIDTH+1)-1:0] i_req_a,
    input  logic [NREQ*(WIDTH+1)-1:0] i_req_b,
    output logic [WIDTH:0]            o_cmp_x,
    output logic [WIDTH:0]            o_cmp_y,
    input  logic                      i_cmp_ge,
    output logic                      o_resp_valid,
    output logic [IDW-1:0]            o_resp_id,
    output logic                      o_resp_ge,
`ifdef FP_CMP_UNORD_EN
    output logic                      o_resp_unord,
`endif
    input  logic                      i_flush,
    output logic                      o_idle
);

    logic [1:0]               r_state;
    logic                     w_en;
    logic [NREQ-1:0]          w_gnt;
    logic [IDW-1:0]           w_gntId;
    logic                     w_any;
    logic [WIDTH:0]           w_selA;
    logic [WIDTH:0]           w_selB;
    logic [CMP_LAT:0]         r_tagValid;
    logic [CMP_LAT:0][IDW-1:0] r_tagId;

    // Grants are suppressed outside RUN and while reset is held.
    assign w_en = (r_state == ST_RUN) && !rst;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_req   (i_req_valid),
        .o_gnt   (w_gnt),
        .o_gntId (w_gntId),
        .o_any   (w_any)
    );

    assign o_req_ready = w_gnt;
    assign o_idle      = (r_state == ST_IDLE);

    always_comb begin
        w_selA = '0;
        w_selB = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_selA = i_req_a[i*(WIDTH+1) +: WIDTH+1];
                w_selB = i_req_b[i*(WIDTH+1) +: WIDTH+1];
            end
        end
    end

    // Operands only move on a transfer so the compare unit sees no toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cmp_x <= '0;
            o_cmp_y <= '0;
        end else if (w_any) begin
            o_cmp_x <= w_selA;
            o_cmp_y <= w_selB;
        end
    end

    // One stage beyond CMP_LAT so the response register samples cmp_ge
    // exactly when the compare unit's result for this tag is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tagValid <= '0;
            r_tagId    <= '0;
        end else begin
            r_tagValid[0] <= w_any;
            r_tagId[0]    <= w_gntId;
            for (int s = 1; s <= CMP_LAT; s++) begin
                r_tagValid[s] <= r_tagValid[s-1];
                r_tagId[s]    <= r_tagId[s-1];
            end
        end
    end

`ifdef FP_CMP_UNORD_EN
    logic [CMP_LAT:0] r_tagUnord;
    logic             w_unord;

    assign w_unord = isNan(w_selA[WIDTH -: 2]) || isNan(w_selB[WIDTH -: 2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tagUnord <= '0;
        end else begin
            r_tagUnord <= {r_tagUnord[CMP_LAT-1:0], w_unord & w_any};
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_resp_valid <= 1'b0;
            o_resp_id    <= '0;
            o_resp_ge    <= 1'b0;
`ifdef FP_CMP_UNORD_EN
            o_resp_unord <= 1'b0;
`endif
        end else begin
            o_resp_valid <= r_tagValid[CMP_LAT];
            o_resp_id    <= r_tagId[CMP_LAT];
`ifdef FP_CMP_UNORD_EN
            o_resp_unord <= r_tagValid[CMP_LAT] & r_tagUnord[CMP_LAT];
            o_resp_ge    <= i_cmp_ge & ~r_tagUnord[CMP_LAT];
`else
            o_resp_ge    <= i_cmp_ge;
`endif
        end
    end

    // Drain always runs to IDLE once entered, even if flush drops early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   if (i_flush) r_state <= ST_DRAIN;
                ST_DRAIN: if (r_tagValid == '0) r_state <= ST_IDLE;
                ST_IDLE:  if (!i_flush) r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Self-checking bench for fp_cmp_arbiter with a CMP_LAT-deep model compare
// unit; responses are checked against a queue of hand-derived expectations.
module tb_fp_cmp_arbiter;

    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int CMP_LAT = 3;
    localparam int OPW     = WIDTH + 1;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       reqValid;
    logic [NREQ-1:0]       reqReady;
    logic [NREQ*OPW-1:0]   reqA;
    logic [NREQ*OPW-1:0]   reqB;
    logic [WIDTH:0]        cmpX;
    logic [WIDTH:0]        cmpY;
    logic                  cmpGe;
    logic                  respValid;
    logic [IDW-1:0]        respId;
    logic                  respGe;
    logic                  flush;
    logic                  idle;
`ifdef FP_CMP_UNORD_EN
    logic                  respUnord;
`endif

    logic [WIDTH:0] opA [NREQ];
    logic [WIDTH:0] opB [NREQ];
    logic           expGe [NREQ];
    logic           expUnord [NREQ];

    typedef struct {
        logic [IDW-1:0] id;
        logic           ge;
        logic           unord;
        int             due;
    } resp_t;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] ready;
    } vec_t;

    resp_t expQ [$];
    vec_t  vecs [16];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    monOn = 1'b0;
    int    dueLast;
    logic [CMP_LAT-1:0] gePipe;

    fp_cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CMP_LAT(CMP_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .i_req_a      (reqA),
        .i_req_b      (reqB),
        .o_cmp_x      (cmpX),
        .o_cmp_y      (cmpY),
        .i_cmp_ge     (cmpGe),
        .o_resp_valid (respValid),
        .o_resp_id    (respId),
        .o_resp_ge    (respGe),
`ifdef FP_CMP_UNORD_EN
        .o_resp_unord (respUnord),
`endif
        .i_flush      (flush),
        .o_idle       (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [WIDTH:0] mkFp(input logic [1:0] exc, input logic sign,
                                            input logic [10:0] e, input logic [18:0] f);
        return {exc, sign, e, f};
    endfunction

    function automatic longint fpKey(input logic [WIDTH:0] x);
        longint m;
        logic [1:0] exc;
        exc = x[WIDTH -: 2];
        case (exc)
            2'b00:   m = 0;
            2'b01:   m = longint'({2'b01, x[29:0]});
            default: m = longint'(32'hC000_0000);
        endcase
        return x[30] ? -m : m;
    endfunction

    function automatic logic fpGe(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic [1:0] ea;
        logic [1:0] eb;
        ea = a[WIDTH -: 2];
        eb = b[WIDTH -: 2];
        if (ea == 2'b11 || eb == 2'b11) return 1'b0;
        return fpKey(a) >= fpKey(b);
    endfunction

    // Model compare unit: result valid CMP_LAT edges after cmp_x/cmp_y load.
    always @(posedge clk) gePipe <= {gePipe[CMP_LAT-2:0], fpGe(cmpX, cmpY)};
    assign cmpGe = gePipe[CMP_LAT-1];

    always_comb begin
        reqA = '0;
        reqB = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqA[i*OPW +: OPW] = opA[i];
            reqB[i*OPW +: OPW] = opB[i];
        end
    end

    function automatic int ohIdx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic pushExp(input int id);
        resp_t r;
        r.id    = IDW'(id);
        r.ge    = expGe[id];
        r.unord = expUnord[id];
        r.due   = cyc + CMP_LAT + 2;
        expQ.push_back(r);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] expReady,
                                 input logic fl);
        @(negedge clk);
        reqValid = valid;
        flush    = fl;
        #1;
        checkOutput("req_ready", reqReady, expReady);
        if (expReady != '0) pushExp(ohIdx(expReady));
    endtask

    // Every cycle: either the oldest expected response is due now, or nothing.
    always @(negedge clk) begin
        if (monOn) begin
            if (expQ.size() > 0 && expQ[0].due == cyc) begin
                checkOutput("resp_valid", respValid, 1);
                checkOutput("resp_id", respId, expQ[0].id);
                checkOutput("resp_ge", respGe, expQ[0].ge);
`ifdef FP_CMP_UNORD_EN
                checkOutput("resp_unord", respUnord, expQ[0].unord);
`endif
                void'(expQ.pop_front());
            end else begin
                checkOutput("resp_quiet", respValid, 0);
`ifdef FP_CMP_UNORD_EN
                checkOutput("unord_quiet", respUnord, 0);
`endif
            end
        end
    end

    initial begin
        opA[0] = mkFp(2'b01, 1'b0, 11'd1024, 19'd0);  opB[0] = mkFp(2'b01, 1'b0, 11'd1023, 19'd0);
        opA[1] = mkFp(2'b01, 1'b0, 11'd1023, 19'd0);  opB[1] = mkFp(2'b01, 1'b0, 11'd1024, 19'd0);
        opA[2] = mkFp(2'b01, 1'b1, 11'd1023, 19'd0);  opB[2] = mkFp(2'b01, 1'b1, 11'd1024, 19'd0);
        opA[3] = mkFp(2'b00, 1'b0, 11'd0,    19'd0);  opB[3] = mkFp(2'b01, 1'b0, 11'd1023, 19'd0);
        expGe[0] = 1'b1;  expGe[1] = 1'b0;  expGe[2] = 1'b1;  expGe[3] = 1'b0;
        for (int i = 0; i < NREQ; i++) expUnord[i] = 1'b0;

        vecs[0]  = '{4'b1111, 4'b0010};
        vecs[1]  = '{4'b1111, 4'b0100};
        vecs[2]  = '{4'b1111, 4'b1000};
        vecs[3]  = '{4'b1111, 4'b0001};
        vecs[4]  = '{4'b1111, 4'b0010};
        vecs[5]  = '{4'b1111, 4'b0100};
        vecs[6]  = '{4'b1111, 4'b1000};
        vecs[7]  = '{4'b0010, 4'b0010};
        vecs[8]  = '{4'b1010, 4'b1000};
        vecs[9]  = '{4'b1010, 4'b0010};
        vecs[10] = '{4'b1010, 4'b1000};
        vecs[11] = '{4'b0000, 4'b0000};
        vecs[12] = '{4'b0100, 4'b0100};
        vecs[13] = '{4'b0000, 4'b0000};
        vecs[14] = '{4'b0011, 4'b0001};
        vecs[15] = '{4'b0000, 4'b0000};

        // Reset state, with a request pending that must not be granted.
        rst      = 1'b1;
        reqValid = 4'b0001;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ready", reqReady, 0);
        checkOutput("rst_cmp_x", cmpX, 0);
        checkOutput("rst_cmp_y", cmpY, 0);
        checkOutput("rst_resp_valid", respValid, 0);
        checkOutput("rst_resp_id", respId, 0);
        checkOutput("rst_resp_ge", respGe, 0);
        checkOutput("rst_idle", idle, 0);
        @(negedge clk);
        rst      = 1'b0;
        reqValid = '0;
        monOn    = 1'b1;

        // Single request latency, then operands must hold.
        applyStimulus(4'b0001, 4'b0001, 1'b0);
        repeat (6) applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("cmp_x_hold", cmpX, opA[0]);
        checkOutput("cmp_y_hold", cmpY, opB[0]);

        // Round-robin and pointer-skip table, pointer starts at 1.
        for (int v = 0; v < 16; v++) applyStimulus(vecs[v].valid, vecs[v].ready, 1'b0);

        // Flush with three in flight; the third grant shares the flush edge.
        applyStimulus(4'b1111, 4'b0010, 1'b0);
        applyStimulus(4'b1111, 4'b0100, 1'b0);
        applyStimulus(4'b1111, 4'b1000, 1'b1);
        dueLast = expQ[expQ.size()-1].due;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            checkOutput("drain_ready", reqReady, 0);
            if (cyc == dueLast) checkOutput("idle_early", idle, 0);
            if (cyc == dueLast + 1) begin
                checkOutput("idle_rise", idle, 1);
                break;
            end
        end
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 4'b0001, 1'b0);
        repeat (5) applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Reset with two in flight: their results must never appear.
        applyStimulus(4'b1111, 4'b0010, 1'b0);
        applyStimulus(4'b1111, 4'b0100, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        reqValid = 4'b1111;
        expQ.delete();
        #1;
        checkOutput("mid_rst_ready", reqReady, 0);
        checkOutput("mid_rst_cmp_x", cmpX, 0);
        checkOutput("mid_rst_resp_valid", respValid, 0);
        checkOutput("mid_rst_idle", idle, 0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        reqValid = '0;
        applyStimulus(4'b1111, 4'b0001, 1'b0);
        repeat (8) applyStimulus(4'b0000, 4'b0000, 1'b0);

`ifdef FP_CMP_UNORD_EN
        opA[1]      = mkFp(2'b11, 1'b0, 11'd0, 19'd0);
        expGe[1]    = 1'b0;
        expUnord[1] = 1'b1;
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        repeat (7) applyStimulus(4'b0000, 4'b0000, 1'b0);
`endif

        repeat (6) applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("queue_empty", expQ.size(), 0);
        monOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
